// File: rtl/acc_pkg.sv
// acc_pkg: shared state type, register map and bit positions
// for the APB accelerator sequencer (apb_acc_ctrl, acc_watchdog).
package acc_pkg;

   localparam int N_ELEM_DEF = 9;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      CAPTURE
   } acc_state_t;

   // word indices (PADDR[11:2])
   localparam logic [9:0] W_CTRL     = 10'd0;
   localparam logic [9:0] W_STATUS   = 10'd1;
   localparam logic [9:0] W_OP_LO    = 10'd2;
   localparam logic [9:0] W_OP_HI    = 10'd6;
   localparam logic [9:0] W_RES_LO   = 10'd7;
   localparam logic [9:0] W_RES_HI   = 10'd11;
   localparam logic [9:0] W_TO_LIMIT = 10'd12;

   // CTRL bits
   localparam int CTRL_START  = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_CLR    = 2;

   // STATUS bits
   localparam int ST_BUSY    = 0;
   localparam int ST_DONE    = 1;
   localparam int ST_TIMEOUT = 2;
   localparam int ST_IRQ_EN  = 3;

endpackage

// File: rtl/acc_watchdog.sv
// acc_watchdog: 16-bit wait-cycle counter; expired flags the last
// allowed cycle. Ports: clk, rst, clr, en, limit[15:0], expired.
module acc_watchdog (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [15:0] limit,
   output logic        expired
);

   logic [15:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 16'd1;
      end
   end

   // limit of 0 means the watchdog never fires
   assign expired = en && (limit != 16'd0) &&
                    (count == limit - 16'd1);

endmodule

// File: rtl/apb_acc_ctrl.sv
// apb_acc_ctrl: APB slave holding operand/result banks for the 3x3
// byte-multiply datapath, sequencing it with start/done and a watchdog.
// Ports: HCLK, HRESET, APB (PADDR..PSLVERR), acc_start, acc_done,
// acc_in_A/B (N_ELEM x 8), acc_out (N_ELEM x 16), irq.
module apb_acc_ctrl
   import acc_pkg::*;
#(
   parameter int          APB_ADDR_WIDTH = 12,
   parameter int          N_ELEM         = N_ELEM_DEF,
   parameter logic [15:0] TO_RESET       = 16'd255
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   output logic                      acc_start,
   input  logic                      acc_done,
   output logic [N_ELEM*8-1:0]       acc_in_A,
   output logic [N_ELEM*8-1:0]       acc_in_B,
   input  logic [N_ELEM*16-1:0]      acc_out,
   output logic                      irq
);

   localparam int N_OP = 2 * N_ELEM;

   acc_state_t  state;
   logic [7:0]  op_q  [N_OP];
   logic [15:0] res_q [N_ELEM];
   logic [15:0] to_limit;
   logic        done_f;
   logic        timeout_f;
   logic        irq_en;
   logic        irq_q;
   logic        start_q;

   logic [9:0]  widx;
   logic        wr;
   logic        busy;
   logic        op_sel;
   logic        res_sel;
   logic        to_sel;
   logic        ctrl_wr;
   logic        start_req;
   logic        op_wr;
   logic        to_wr;
   logic        start_go;
   logic        expired;
   logic        unused_addr;

   assign widx        = PADDR[11:2];
   assign unused_addr = ^PADDR[1:0];

   assign wr      = PSEL && PENABLE && PWRITE;
   assign busy    = (state != IDLE);
   assign op_sel  = (widx >= W_OP_LO) && (widx <= W_OP_HI);
   assign res_sel = (widx >= W_RES_LO) && (widx <= W_RES_HI);
   assign to_sel  = (widx == W_TO_LIMIT);
   assign ctrl_wr = wr && (widx == W_CTRL);

   assign start_req = ctrl_wr && PWDATA[CTRL_START];
   assign op_wr     = wr && op_sel && !busy;
   assign to_wr     = wr && to_sel && !busy;
   assign start_go  = start_req && !busy;

   // only accesses that would disturb a running operation are refused
   assign PSLVERR = busy &&
                    ((wr && (op_sel || to_sel)) || start_req);
   assign PREADY  = 1'b1;

   acc_watchdog u_wdog (
      .clk     (HCLK),
      .rst     (HRESET),
      .clr     (state == ISSUE),
      .en      (state == WAIT),
      .limit   (to_limit),
      .expired (expired)
   );

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state     <= IDLE;
         to_limit  <= TO_RESET;
         done_f    <= 1'b0;
         timeout_f <= 1'b0;
         irq_en    <= 1'b0;
         irq_q     <= 1'b0;
         start_q   <= 1'b0;
         for (int i = 0; i < N_OP; i++) op_q[i] <= '0;
         for (int i = 0; i < N_ELEM; i++) res_q[i] <= '0;
      end else begin
         start_q <= 1'b0;
         irq_q   <= irq_en && (done_f || timeout_f);

         if (ctrl_wr) begin
            irq_en <= PWDATA[CTRL_IRQ_EN];
            if (PWDATA[CTRL_CLR]) begin
               done_f    <= 1'b0;
               timeout_f <= 1'b0;
            end
         end

         if (start_go) begin
            done_f    <= 1'b0;
            timeout_f <= 1'b0;
         end

         for (int i = 0; i < N_OP; i++) begin
            if (op_wr && widx == 10'(W_OP_LO + i / 4))
               op_q[i] <= PWDATA[8*(i%4) +: 8];
         end

         if (to_wr) to_limit <= PWDATA[15:0];

         // flag sets come last so they win over a same-cycle CLR
         unique case (state)
            IDLE: begin
               if (start_go) begin
                  state   <= ISSUE;
                  start_q <= 1'b1;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (acc_done) begin
                  state <= CAPTURE;
               end else if (expired) begin
                  timeout_f <= 1'b1;
                  state     <= IDLE;
               end
            end
            CAPTURE: begin
               for (int i = 0; i < N_ELEM; i++)
                  res_q[i] <= acc_out[16*i +: 16];
               done_f <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      PRDATA = 32'hFFFF_FFFF;
      if (widx == W_CTRL) begin
         PRDATA = '0;
      end else if (widx == W_STATUS) begin
         PRDATA = '0;
         PRDATA[ST_BUSY]    = busy;
         PRDATA[ST_DONE]    = done_f;
         PRDATA[ST_TIMEOUT] = timeout_f;
         PRDATA[ST_IRQ_EN]  = irq_en;
      end else if (op_sel) begin
         PRDATA = '0;
         for (int i = 0; i < N_OP; i++) begin
            if (widx == 10'(W_OP_LO + i / 4))
               PRDATA[8*(i%4) +: 8] = op_q[i];
         end
      end else if (res_sel) begin
         PRDATA = '0;
         for (int i = 0; i < N_ELEM; i++) begin
            if (widx == 10'(W_RES_LO + i / 2))
               PRDATA[16*(i%2) +: 16] = res_q[i];
         end
      end else if (to_sel) begin
         PRDATA = {16'd0, to_limit};
      end
   end

   for (genvar g = 0; g < N_ELEM; g++) begin : g_ops
      assign acc_in_A[8*g +: 8] = op_q[g];
      assign acc_in_B[8*g +: 8] = op_q[N_ELEM + g];
   end

   assign acc_start = start_q;
   assign irq       = irq_q;

endmodule
